// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl
// Description : Run controller for the 16-bit RISC core. Holds the core in
//               reset for RST_CYCLES after start, counts RUN cycles until the
//               core halts or the run times out, then streams the register
//               file out over a valid/ready dump port.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               start            - begin a run (IDLE or DONE only)
//               cpu_rst          - reset to the core
//               cpu_halted       - core halted flag (sampled in RUN only)
//               dbg_raddr/rdata  - register-file debug read port
//               dump_valid/ready - dump handshake
//               dump_idx/data    - dumped register index and value
//               cycle_count      - RUN cycles in current/last run
//               busy/done        - status; timed_out - last run timed out
// Revision    : 1.0 - initial release
// ============================================================================
module run_ctrl #(
   parameter int DATA_W     = 16,
   parameter int NREGS      = 16,
   parameter int REG_AW     = 4,
   parameter int RST_CYCLES = 2,
   parameter int TIMEOUT    = 1000,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              cpu_rst,
   input  logic              cpu_halted,
   output logic [REG_AW-1:0] dbg_raddr,
   input  logic [DATA_W-1:0] dbg_rdata,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [REG_AW-1:0] dump_idx,
   output logic [DATA_W-1:0] dump_data,
   output logic [CNT_W-1:0]  cycle_count,
   output logic              busy,
   output logic              done,
   output logic              timed_out
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RESET = 3'd1,
      S_RUN   = 3'd2,
      S_DUMP  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Reset counter only needs to reach RST_CYCLES-1.
   localparam int              c_rcnt_w   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [c_rcnt_w-1:0] c_rcnt_last = c_rcnt_w'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]    c_timeout   = CNT_W'(TIMEOUT);
   localparam logic [REG_AW-1:0]   c_last_idx  = REG_AW'(NREGS - 1);

   state_t              r_state,       w_state_nxt;
   logic                r_cpu_rst,     w_cpu_rst_nxt;
   logic [REG_AW-1:0]   r_dbg_raddr,   w_dbg_raddr_nxt;
   logic                r_dump_valid,  w_dump_valid_nxt;
   logic [REG_AW-1:0]   r_dump_idx,    w_dump_idx_nxt;
   logic [DATA_W-1:0]   r_dump_data,   w_dump_data_nxt;
   logic [CNT_W-1:0]    r_cycle_count, w_cycle_count_nxt;
   logic                r_done,        w_done_nxt;
   logic                r_timed_out,   w_timed_out_nxt;
   logic [c_rcnt_w-1:0] r_rst_cnt,     w_rst_cnt_nxt;
   logic [CNT_W-1:0]    w_cnt_inc;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   assign w_cnt_inc = (&r_cycle_count) ? r_cycle_count : r_cycle_count + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cpu_rst     <= 1'b1;
         r_dbg_raddr   <= '0;
         r_dump_valid  <= 1'b0;
         r_dump_idx    <= '0;
         r_dump_data   <= '0;
         r_cycle_count <= '0;
         r_done        <= 1'b0;
         r_timed_out   <= 1'b0;
         r_rst_cnt     <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_cpu_rst     <= w_cpu_rst_nxt;
         r_dbg_raddr   <= w_dbg_raddr_nxt;
         r_dump_valid  <= w_dump_valid_nxt;
         r_dump_idx    <= w_dump_idx_nxt;
         r_dump_data   <= w_dump_data_nxt;
         r_cycle_count <= w_cycle_count_nxt;
         r_done        <= w_done_nxt;
         r_timed_out   <= w_timed_out_nxt;
         r_rst_cnt     <= w_rst_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_cpu_rst_nxt     = r_cpu_rst;
      w_dbg_raddr_nxt   = r_dbg_raddr;
      w_dump_valid_nxt  = r_dump_valid;
      w_dump_idx_nxt    = r_dump_idx;
      w_dump_data_nxt   = r_dump_data;
      w_cycle_count_nxt = r_cycle_count;
      w_done_nxt        = r_done;
      w_timed_out_nxt   = r_timed_out;
      w_rst_cnt_nxt     = r_rst_cnt;

      case (r_state)
         S_IDLE: begin
            w_cpu_rst_nxt = 1'b1;
            if (start) begin
               w_state_nxt       = S_RESET;
               w_cycle_count_nxt = '0;
               w_done_nxt        = 1'b0;
               w_timed_out_nxt   = 1'b0;
               w_rst_cnt_nxt     = '0;
            end
         end

         S_RESET: begin
            w_cpu_rst_nxt = 1'b1;
            if (r_rst_cnt == c_rcnt_last) begin
               // Release is registered so cpu_rst is low on the first RUN cycle.
               w_state_nxt   = S_RUN;
               w_cpu_rst_nxt = 1'b0;
            end else begin
               w_rst_cnt_nxt = r_rst_cnt + 1'b1;
            end
         end

         S_RUN: begin
            w_cpu_rst_nxt = 1'b0;
            if (cpu_halted) begin
               // Halt takes priority over a coincident timeout.
               w_state_nxt      = S_DUMP;
               w_dbg_raddr_nxt  = '0;
               w_dump_valid_nxt = 1'b0;
            end else begin
               w_cycle_count_nxt = w_cnt_inc;
               if (w_cnt_inc == c_timeout) begin
                  w_state_nxt     = S_DONE;
                  w_timed_out_nxt = 1'b1;
                  w_done_nxt      = 1'b1;
                  w_cpu_rst_nxt   = 1'b1;
               end
            end
         end

         S_DUMP: begin
            // Core is kept out of reset so its register file stays readable.
            w_cpu_rst_nxt = 1'b0;
            if (!r_dump_valid) begin
               w_dump_data_nxt  = dbg_rdata;
               w_dump_idx_nxt   = r_dbg_raddr;
               w_dump_valid_nxt = 1'b1;
            end else if (dump_ready) begin
               w_dump_valid_nxt = 1'b0;
               if (r_dump_idx == c_last_idx) begin
                  w_state_nxt   = S_DONE;
                  w_done_nxt    = 1'b1;
                  w_cpu_rst_nxt = 1'b1;
               end else begin
                  w_dbg_raddr_nxt = r_dbg_raddr + 1'b1;
               end
            end
         end

         S_DONE: begin
            w_cpu_rst_nxt = 1'b1;
            w_done_nxt    = 1'b1;
            if (start) begin
               w_state_nxt       = S_RESET;
               w_cycle_count_nxt = '0;
               w_done_nxt        = 1'b0;
               w_timed_out_nxt   = 1'b0;
               w_rst_cnt_nxt     = '0;
            end
         end

         default: begin
            w_state_nxt   = S_IDLE;
            w_cpu_rst_nxt = 1'b1;
         end
      endcase
   end

   assign cpu_rst     = r_cpu_rst;
   assign dbg_raddr   = r_dbg_raddr;
   assign dump_valid  = r_dump_valid;
   assign dump_idx    = r_dump_idx;
   assign dump_data   = r_dump_data;
   assign cycle_count = r_cycle_count;
   assign done        = r_done;
   assign timed_out   = r_timed_out;
   assign busy        = (r_state == S_RESET) || (r_state == S_RUN) || (r_state == S_DUMP);

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_ctrl
// Description : Directed testbench for run_ctrl (RST_CYCLES=2, TIMEOUT=20).
//               A combinational register-file model answers dbg_raddr with
//               rf_base + index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_ctrl;

   localparam int DATA_W = 16;
   localparam int NREGS  = 16;
   localparam int REG_AW = 4;
   localparam int CNT_W  = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              cpu_rst;
   logic              cpu_halted;
   logic [REG_AW-1:0] dbg_raddr;
   logic [DATA_W-1:0] dbg_rdata;
   logic              dump_valid;
   logic              dump_ready;
   logic [REG_AW-1:0] dump_idx;
   logic [DATA_W-1:0] dump_data;
   logic [CNT_W-1:0]  cycle_count;
   logic              busy;
   logic              done;
   logic              timed_out;

   logic [DATA_W-1:0] rf_base;
   int                n_tests = 0;
   int                n_fail  = 0;
   int                valid_cycles = 0;

   always #5 clk = ~clk;

   assign dbg_rdata = rf_base + DATA_W'(dbg_raddr);

   always @(posedge clk) if (dump_valid) valid_cycles <= valid_cycles + 1;

   run_ctrl #(
      .DATA_W(DATA_W), .NREGS(NREGS), .REG_AW(REG_AW),
      .RST_CYCLES(2), .TIMEOUT(20), .CNT_W(CNT_W)
   ) u_dut (
      .clk(clk), .rst(rst), .start(start), .cpu_rst(cpu_rst),
      .cpu_halted(cpu_halted), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
      .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
      .dump_data(dump_data), .cycle_count(cycle_count), .busy(busy),
      .done(done), .timed_out(timed_out)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start pulse then walk through the two reset cycles to the first RUN cycle.
   task automatic start_run();
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_done_clr", done, 0);
      check("start_to_clr", timed_out, 0);
      check("start_cnt_clr", cycle_count, 0);
      check("rst_cyc1", cpu_rst, 1);
      step();
      check("rst_cyc2", cpu_rst, 1);
      step();
      check("run_cpu_rst", cpu_rst, 0);
   endtask

   // Drain a full dump, checking order, data and hold stability.
   task automatic collect_dump(input bit bp);
      int                k = 0;
      int                wait_cnt = 0;
      bit                holding = 1'b0;
      logic [REG_AW-1:0] h_idx = '0;
      logic [DATA_W-1:0] h_data = '0;
      for (int budget = 0; budget < 400 && k < NREGS; budget++) begin
         if (holding) begin
            check("hold_valid", dump_valid, 1);
            check("hold_idx", dump_idx, h_idx);
            check("hold_data", dump_data, h_data);
         end
         if (dump_valid) begin
            if (!bp || wait_cnt >= 4) begin
               dump_ready = 1'b1;
               check("word_idx", dump_idx, k);
               check("word_data", dump_data, rf_base + DATA_W'(k));
               k++;
               wait_cnt = 0;
               holding  = 1'b0;
            end else begin
               dump_ready = 1'b0;
               wait_cnt++;
               holding = 1'b1;
               h_idx   = dump_idx;
               h_data  = dump_data;
            end
         end else begin
            dump_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            holding    = 1'b0;
         end
         step();
      end
      dump_ready = 1'b0;
      check("dump_words", k, NREGS);
   endtask

   initial begin
      int snap;
      rst = 1'b1; start = 1'b1; cpu_halted = 1'b0; dump_ready = 1'b0;
      rf_base = 16'h1000;

      // ---- reset ----
      repeat (3) step();
      check("rst_cpu_rst", cpu_rst, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", dump_valid, 0);
      check("rst_cnt", cycle_count, 0);
      check("rst_idx", dump_idx, 0);
      check("rst_data", dump_data, 0);
      check("rst_to", timed_out, 0);
      rst = 1'b0; start = 1'b0;
      repeat (3) step();
      check("idle_busy", busy, 0);
      check("idle_cpu_rst", cpu_rst, 1);

      // ---- halt after 5 RUN cycles, ready always high ----
      start_run();
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);          // start is ignored in RUN
         step();
      end
      start = 1'b0;
      check("halt_pre_cnt", cycle_count, 5);
      cpu_halted = 1'b1;
      step();
      check("halt_cnt", cycle_count, 5);
      check("halt_busy", busy, 1);
      check("halt_valid0", dump_valid, 0);
      check("dump_cpu_rst", cpu_rst, 0);
      step();
      check("halt_valid1", dump_valid, 1);
      collect_dump(1'b0);
      check("end_done", done, 1);
      check("end_to", timed_out, 0);
      check("end_cpu_rst", cpu_rst, 1);
      check("end_cnt", cycle_count, 5);
      check("end_busy", busy, 0);
      cpu_halted = 1'b0;

      // ---- back-pressure rerun from DONE ----
      rf_base = 16'h2000;
      start_run();
      repeat (3) step();
      cpu_halted = 1'b1;
      step();
      cpu_halted = 1'b0;
      check("bp_cnt", cycle_count, 3);
      collect_dump(1'b1);
      check("bp_done", done, 1);

      // ---- timeout ----
      snap = valid_cycles;
      start_run();
      repeat (19) step();
      check("to_pre_cnt", cycle_count, 19);
      check("to_pre_done", done, 0);
      step();
      check("to_done", done, 1);
      check("to_flag", timed_out, 1);
      check("to_cnt", cycle_count, 20);
      check("to_cpu_rst", cpu_rst, 1);
      repeat (3) step();
      check("to_no_dump", valid_cycles - snap, 0);
      check("to_hold_cnt", cycle_count, 20);

      // ---- halt on the timeout cycle (also clears timed_out on rerun) ----
      rf_base = 16'h3000;
      start_run();
      repeat (19) step();
      cpu_halted = 1'b1;
      step();
      cpu_halted = 1'b0;
      check("ht_cnt", cycle_count, 19);
      check("ht_to", timed_out, 0);
      check("ht_busy", busy, 1);
      collect_dump(1'b0);
      check("ht_done", done, 1);
      check("ht_to_end", timed_out, 0);

      // ---- reset during DUMP at idx 7 ----
      rf_base = 16'h4000;
      start_run();
      repeat (2) step();
      cpu_halted = 1'b1;
      step();
      cpu_halted = 1'b0;
      for (int b = 0; b < 100; b++) begin
         if (dump_valid && dump_idx == 4'd7) break;
         dump_ready = 1'b1;
         step();
      end
      check("mid_idx", dump_idx, 7);
      check("mid_valid", dump_valid, 1);
      dump_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_valid", dump_valid, 0);
      check("mid_rst_cpu_rst", cpu_rst, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_cnt", cycle_count, 0);
      step();
      check("mid_idle_busy", busy, 0);
      check("mid_idle_valid", dump_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
